// File: rtl/a2d_sched_if.sv
// a2d_sched_if: handshake bundle between the system timing/control logic
// (master) and the A2D conversion scheduler (slave).
// The on-demand request is called force_req because "force" is a reserved word.
interface a2d_sched_if;
    logic       en;
    logic       force_req;
    logic       cnv_done;
    logic [3:0] ch_clr;
    logic       err_clr;
    logic       nxt;
    logic [1:0] ch_idx;
    logic [3:0] ch_vld;
    logic       sweep_done;
    logic       busy;
    logic       timeout_err;
    logic       overrun;

    modport master (
        output en, force_req, cnv_done, ch_clr, err_clr,
        input  nxt, ch_idx, ch_vld, sweep_done, busy, timeout_err, overrun
    );

    modport slave (
        input  en, force_req, cnv_done, ch_clr, err_clr,
        output nxt, ch_idx, ch_vld, sweep_done, busy, timeout_err, overrun
    );
endinterface

// File: rtl/a2d_sched.sv
// a2d_sched: conversion scheduler for the A2D interface. Issues one-cycle
// nxt requests on a programmable period or on demand, walks the four
// channel slots round-robin, keeps per-channel fresh-data flags and flags
// lost period ticks (overrun) and hung conversions (timeout).
module a2d_sched #(
    parameter int PERIOD  = 4096,
    parameter int TIMEOUT = 2048
) (
    input logic         clk,
    input logic         rst_n,
    a2d_sched_if.slave  bus
);

    localparam int PW = (PERIOD  > 1) ? $clog2(PERIOD)  : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] period_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          pending;
    logic          nxt_q;
    logic [1:0]    ch_idx_q;
    logic [3:0]    ch_vld_q;
    logic          sweep_q;
    logic          timeout_q;
    logic          overrun_q;

    logic          tick;
    logic          req;
    logic          issue;
    logic          accept;
    logic          expire;
    logic [3:0]    set_mask;

    assign tick     = bus.en && (period_cnt == PW'(PERIOD - 1));
    assign req      = tick || (bus.force_req && bus.en);
    assign set_mask = accept ? (4'b0001 << ch_idx_q) : 4'b0000;

    // State register for the IDLE/BUSY/FAULT conversion tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: issue from IDLE, complete or time out in BUSY,
    // accept late completions in FAULT so ch_idx stays aligned with the
    // A2D interface, and leave FAULT only on err_clr.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        accept    = 1'b0;
        expire    = 1'b0;
        case (state)
            IDLE: begin
                if (pending && bus.en) begin
                    issue     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (bus.cnv_done) begin
                    accept    = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    expire    = 1'b1;
                    state_nxt = FAULT;
                end
            end
            FAULT: begin
                accept = bus.cnv_done;
                if (bus.err_clr) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Free-running period counter, parked at zero whenever scheduling is off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               period_cnt <= '0;
        else if (!bus.en)                         period_cnt <= '0;
        else if (period_cnt == PW'(PERIOD - 1))   period_cnt <= '0;
        else                                      period_cnt <= period_cnt + PW'(1);
    end

    // One-deep request latch; a new request in the issuing cycle re-arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       pending <= 1'b0;
        else if (!bus.en) pending <= 1'b0;
        else if (req)     pending <= 1'b1;
        else if (issue)   pending <= 1'b0;
    end

    // Cycles spent waiting for cnv_done since the last nxt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              tmo_cnt <= '0;
        else if (issue)          tmo_cnt <= '0;
        else if (state == BUSY)  tmo_cnt <= tmo_cnt + TW'(1);
    end

    // Registered request strobe and completion bookkeeping per channel slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nxt_q    <= 1'b0;
            ch_idx_q <= 2'd0;
            ch_vld_q <= 4'b0000;
            sweep_q  <= 1'b0;
        end else begin
            nxt_q    <= issue;
            sweep_q  <= accept && (ch_idx_q == 2'd3);
            ch_vld_q <= (ch_vld_q & ~bus.ch_clr) | set_mask;
            if (accept) ch_idx_q <= ch_idx_q + 2'd1;
        end
    end

    // Sticky error flags; a new error in the clearing cycle takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (expire)           timeout_q <= 1'b1;
            else if (bus.err_clr) timeout_q <= 1'b0;
            if (req && pending && !issue) overrun_q <= 1'b1;
            else if (bus.err_clr)         overrun_q <= 1'b0;
        end
    end

    assign bus.nxt         = nxt_q;
    assign bus.ch_idx      = ch_idx_q;
    assign bus.ch_vld      = ch_vld_q;
    assign bus.sweep_done  = sweep_q;
    assign bus.busy        = (state != IDLE);
    assign bus.timeout_err = timeout_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_a2d_sched.sv
// tb_a2d_sched: self-checking bench for the A2D conversion scheduler.
// A behavioural model tracks the scheduler's observable rules; an A2D
// responder returns cnv_done a chosen latency after each modelled nxt.
module tb_a2d_sched;

    localparam int PERIOD  = 16;
    localparam int TIMEOUT = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    a2d_sched_if ifc ();

    a2d_sched #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    bit       en_i, frc_i, done_i, eclr_i, auto_done;
    bit [3:0] clr_i;
    int       lat_lo, lat_hi, resp_cnt;

    int       m_phase, m_age, m_slot;
    bit       m_pending, m_in_flight, m_faulted;
    bit       m_nxt, m_sweep, m_terr, m_ovr;
    bit [3:0] m_vld;

    function automatic logic [10:0] got_vec();
        return {ifc.nxt, ifc.ch_idx, ifc.ch_vld, ifc.sweep_done, ifc.busy,
                ifc.timeout_err, ifc.overrun};
    endfunction

    function automatic logic [10:0] exp_vec();
        logic [1:0] slot;
        slot = 2'(m_slot);
        return {m_nxt, slot, m_vld, m_sweep, (m_in_flight | m_faulted), m_terr, m_ovr};
    endfunction

    function automatic void model_reset();
        m_phase = 0; m_age = 0; m_slot = 0;
        m_pending = 0; m_in_flight = 0; m_faulted = 0;
        m_nxt = 0; m_sweep = 0; m_terr = 0; m_ovr = 0; m_vld = 4'b0000;
    endfunction

    function automatic void model_step(bit en, bit frc, bit done, bit [3:0] clr, bit eclr);
        bit tick, req, issue, accept, expire, ovr_set;
        tick    = en && (m_phase == PERIOD - 1);
        req     = tick || (frc && en);
        issue   = en && m_pending && !m_in_flight && !m_faulted;
        accept  = done && (m_in_flight || m_faulted);
        expire  = m_in_flight && !done && (m_age == TIMEOUT - 1);
        ovr_set = req && m_pending && !issue;
        m_phase = en ? (m_phase + 1) % PERIOD : 0;
        if (!en)        m_pending = 0;
        else if (req)   m_pending = 1;
        else if (issue) m_pending = 0;
        m_vld   = m_vld & ~clr;
        m_sweep = accept && (m_slot == 3);
        if (accept) begin
            m_vld[m_slot] = 1'b1;
            m_slot = (m_slot + 1) % 4;
        end
        m_nxt = issue;
        m_age = issue ? 0 : m_age + 1;
        if (issue)                  m_in_flight = 1;
        else if (accept || expire)  m_in_flight = 0;
        if (expire)     m_faulted = 1;
        else if (eclr)  m_faulted = 0;
        m_terr = expire  ? 1'b1 : (eclr ? 1'b0 : m_terr);
        m_ovr  = ovr_set ? 1'b1 : (eclr ? 1'b0 : m_ovr);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        ifc.en = 0; ifc.force_req = 0; ifc.cnv_done = 0; ifc.ch_clr = 0; ifc.err_clr = 0;
        en_i = 0; frc_i = 0; done_i = 0; clr_i = 0; eclr_i = 0;
        auto_done = 0; lat_lo = 1; lat_hi = 1; resp_cnt = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cycle();
        @(negedge clk);
        ifc.en        = en_i;
        ifc.force_req = frc_i;
        ifc.cnv_done  = done_i || (auto_done && resp_cnt == 1);
        ifc.ch_clr    = clr_i;
        ifc.err_clr   = eclr_i;
        @(posedge clk);
        model_step(ifc.en, ifc.force_req, ifc.cnv_done, ifc.ch_clr, ifc.err_clr);
        if (resp_cnt > 0) resp_cnt--;
        if (m_nxt) resp_cnt = $urandom_range(lat_hi, lat_lo);
        frc_i = 0; done_i = 0; clr_i = 0; eclr_i = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if (got_vec() !== 11'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got %b want %b", got_vec(), 11'd0);
        end
    endtask

    task automatic test_periodic();
        int nxt_seen = 0;
        int sweeps = 0;
        do_reset();
        en_i = 1; auto_done = 1; lat_lo = 5; lat_hi = 5;
        for (int c = 0; c < 96; c++) begin
            cycle();
            vectors++;
            if (got_vec() !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL periodic cyc %0d: got %b want %b", c, got_vec(), exp_vec());
            end
            if (ifc.nxt) nxt_seen++;
            if (ifc.sweep_done) sweeps++;
        end
        vectors++;
        if (nxt_seen != 5 || sweeps != 1) begin
            miscompares++;
            $display("[TB] FAIL periodic_counts: nxt %0d sweeps %0d want 5 and 1", nxt_seen, sweeps);
        end
        vectors++;
        if (ifc.ch_vld !== 4'b1111 || ifc.ch_idx !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL periodic_final: ch_vld %b ch_idx %0d want 1111 and 1",
                     ifc.ch_vld, ifc.ch_idx);
        end
    endtask

    task automatic test_en_gate();
        int nxt_seen = 0;
        do_reset();
        en_i = 0; frc_i = 1;
        cycle();
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (ifc.nxt) nxt_seen++;
        end
        vectors++;
        if (nxt_seen != 0 || ifc.busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL en_gate_off: nxt count %0d busy %b want 0 and 0", nxt_seen, ifc.busy);
        end
        en_i = 1; auto_done = 1; lat_lo = 5; lat_hi = 5;
        cycle();
        cycle();
        frc_i = 1;
        cycle();
        vectors++;
        if (ifc.nxt !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL force_latency_early: nxt %b want 0", ifc.nxt);
        end
        cycle();
        vectors++;
        if (ifc.nxt !== 1'b1 || ifc.busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL force_issue: nxt %b busy %b want 1 1", ifc.nxt, ifc.busy);
        end
        for (int c = 0; c < 4; c++) begin
            cycle();
            vectors++;
            if (ifc.busy !== 1'b1 || got_vec() !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL busy_hold cyc %0d: got %b want %b", c, got_vec(), exp_vec());
            end
        end
        cycle();
        vectors++;
        if (ifc.busy !== 1'b0 || ifc.ch_idx !== 2'd1 || ifc.ch_vld !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL force_complete: busy %b ch_idx %0d ch_vld %b want 0 1 0001",
                     ifc.busy, ifc.ch_idx, ifc.ch_vld);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        en_i = 1; auto_done = 1; lat_lo = 20; lat_hi = 20;
        frc_i = 1;
        cycle();
        cycle();
        cycle();
        cycle();
        frc_i = 1;
        cycle();
        vectors++;
        if (ifc.overrun !== 1'b0 || ifc.busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL overrun_first_pending: overrun %b busy %b want 0 1", ifc.overrun, ifc.busy);
        end
        cycle();
        frc_i = 1;
        cycle();
        vectors++;
        if (ifc.overrun !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL overrun_set: overrun %b want 1", ifc.overrun);
        end
        cycle();
        vectors++;
        if (ifc.overrun !== 1'b1 || got_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL overrun_sticky: got %b want %b", got_vec(), exp_vec());
        end
        eclr_i = 1;
        cycle();
        vectors++;
        if (ifc.overrun !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL overrun_clear: overrun %b want 0", ifc.overrun);
        end
    endtask

    task automatic test_timeout();
        int nxt_seen = 0;
        do_reset();
        en_i = 1; auto_done = 0;
        for (int c = 0; c < 100; c++) begin
            cycle();
            vectors++;
            if (got_vec() !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL timeout_run cyc %0d: got %b want %b", c, got_vec(), exp_vec());
            end
            if (ifc.nxt) nxt_seen++;
            if (c == 59) begin
                vectors++;
                if (ifc.timeout_err !== 1'b1 || ifc.busy !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL timeout_set: timeout_err %b busy %b want 1 1",
                             ifc.timeout_err, ifc.busy);
                end
            end
        end
        vectors++;
        if (nxt_seen != 1) begin
            miscompares++;
            $display("[TB] FAIL fault_suppress: nxt count %0d want 1", nxt_seen);
        end
        done_i = 1;
        cycle();
        vectors++;
        if (ifc.ch_idx !== 2'd1 || ifc.ch_vld !== 4'b0001 || ifc.busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL late_done: ch_idx %0d ch_vld %b busy %b want 1 0001 1",
                     ifc.ch_idx, ifc.ch_vld, ifc.busy);
        end
        eclr_i = 1;
        cycle();
        vectors++;
        if (ifc.timeout_err !== 1'b0 || ifc.busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL fault_release: timeout_err %b busy %b want 0 0",
                     ifc.timeout_err, ifc.busy);
        end
        cycle();
        vectors++;
        if (ifc.nxt !== 1'b1 || ifc.ch_idx !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL resume_nxt: nxt %b ch_idx %0d want 1 1", ifc.nxt, ifc.ch_idx);
        end
    endtask

    task automatic test_ch_clr();
        do_reset();
        en_i = 1;
        frc_i = 1;
        cycle();
        cycle();
        cycle();
        done_i = 1; clr_i = 4'b0001;
        cycle();
        vectors++;
        if (ifc.ch_vld !== 4'b0001 || got_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL clr_vs_set: ch_vld %b want 0001 (vec %b want %b)",
                     ifc.ch_vld, got_vec(), exp_vec());
        end
        clr_i = 4'b0001;
        cycle();
        vectors++;
        if (ifc.ch_vld !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL clr_alone: ch_vld %b want 0000", ifc.ch_vld);
        end
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        en_i = 1; auto_done = 1; lat_lo = 3; lat_hi = 3;
        frc_i = 1;
        cycle();
        repeat (6) cycle();
        vectors++;
        if (ifc.ch_idx !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_idx: ch_idx %0d want 1", ifc.ch_idx);
        end
        lat_lo = 20; lat_hi = 20;
        frc_i = 1;
        cycle();
        cycle();
        cycle();
        vectors++;
        if (ifc.busy !== 1'b1 || got_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_busy: got %b want %b", got_vec(), exp_vec());
        end
        #2;
        rst_n = 1'b0;
        ifc.en = 0; ifc.force_req = 0; ifc.cnv_done = 0; ifc.ch_clr = 0; ifc.err_clr = 0;
        #1;
        vectors++;
        if (got_vec() !== 11'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got %b want %b", got_vec(), 11'd0);
        end
        model_reset();
        resp_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        frc_i = 1;
        cycle();
        cycle();
        vectors++;
        if (ifc.nxt !== 1'b1 || ifc.ch_idx !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL post_reset_nxt: nxt %b ch_idx %0d want 1 0", ifc.nxt, ifc.ch_idx);
        end
    endtask

    task automatic test_random();
        do_reset();
        en_i = 1; auto_done = 1; lat_lo = 1; lat_hi = 40;
        for (int c = 0; c < 3000; c++) begin
            if (en_i) begin
                if ($urandom_range(199) == 0) en_i = 0;
            end else if ($urandom_range(99) < 20) begin
                en_i = 1;
            end
            frc_i  = ($urandom_range(99) < 6);
            done_i = ($urandom_range(99) < 1);
            clr_i  = ($urandom_range(99) < 10) ? 4'($urandom_range(15)) : 4'b0000;
            eclr_i = ($urandom_range(99) < 3);
            cycle();
            vectors++;
            if (got_vec() !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL random cyc %0d: got %b want %b", c, got_vec(), exp_vec());
            end
        end
    endtask

    // Watchdog so the run always ends even if a task stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_periodic();
        test_en_gate();
        test_overrun();
        test_timeout();
        test_ch_clr();
        test_reset_mid_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
